// File: rtl/ram_dma.sv
// ram_dma: block copy / constant fill engine that masters a single-port byte RAM.
// Optional macro DMA_BACKWARD_COPY_EN: overlapping copies with dst above src run descending (memmove).
module ram_dma #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              aborted,
  output logic [ADDR_W-1:0] count_left,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   ONE_X = (ADDR_W+1)'(1);

  state_t            state;
  logic              mode_r;
  logic              dir_down;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [ADDR_W-1:0] src_next;
  logic [ADDR_W-1:0] dst_next;
  logic [ADDR_W:0]   src_end;
  logic [ADDR_W:0]   dst_end;
  logic              range_bad;
  logic              backward;
  logic [ADDR_W-1:0] start_src;
  logic [ADDR_W-1:0] start_dst;

  // Last byte addresses in one extra bit so a wrap past the top of memory shows up as bit ADDR_W.
  assign src_end   = {1'b0, src_addr} + {1'b0, length} - ONE_X;
  assign dst_end   = {1'b0, dst_addr} + {1'b0, length} - ONE_X;
  assign range_bad = (length != '0) && ((!mode && src_end[ADDR_W]) || dst_end[ADDR_W]);

`ifdef DMA_BACKWARD_COPY_EN
  assign backward = !mode && (dst_addr > src_addr) && ({1'b0, dst_addr} <= src_end);
`else
  assign backward = 1'b0;
`endif

  assign start_src = backward ? src_end[ADDR_W-1:0] : src_addr;
  assign start_dst = backward ? dst_end[ADDR_W-1:0] : dst_addr;
  assign src_next  = dir_down ? (src_ptr - ONE) : (src_ptr + ONE);
  assign dst_next  = dir_down ? (dst_ptr - ONE) : (dst_ptr + ONE);

  // mem_wdata doubles as the byte buffer: a copy's read lands here and is written out next.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      mode_r     <= 1'b0;
      dir_down   <= 1'b0;
      src_ptr    <= '0;
      dst_ptr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      aborted    <= 1'b0;
      count_left <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (range_bad) begin
              error <= 1'b1;
            end else if (length == '0) begin
              state      <= FIN;
              done       <= 1'b1;
              count_left <= '0;
            end else begin
              mode_r     <= mode;
              dir_down   <= backward;
              src_ptr    <= start_src;
              dst_ptr    <= start_dst;
              count_left <= length;
              busy       <= 1'b1;
              if (mode) begin
                state     <= WRITE;
                mem_we    <= 1'b1;
                mem_addr  <= start_dst;
                mem_wdata <= fill_value;
              end else begin
                state    <= READ;
                mem_re   <= 1'b1;
                mem_addr <= start_src;
              end
            end
          end
        end

        READ: begin
          if (mem_ready) begin
            mem_wdata <= mem_rdata;
            mem_re    <= 1'b0;
            if (abort) begin
              state   <= FIN;
              done    <= 1'b1;
              aborted <= 1'b1;
              busy    <= 1'b0;
            end else begin
              state    <= WRITE;
              mem_we   <= 1'b1;
              mem_addr <= dst_ptr;
            end
          end else if (abort) begin
            state   <= FIN;
            done    <= 1'b1;
            aborted <= 1'b1;
            busy    <= 1'b0;
            mem_re  <= 1'b0;
          end
        end

        WRITE: begin
          if (mem_ready) begin
            count_left <= count_left - ONE;
            src_ptr    <= src_next;
            dst_ptr    <= dst_next;
            if (count_left == ONE || abort) begin
              state   <= FIN;
              done    <= 1'b1;
              aborted <= abort;
              busy    <= 1'b0;
              mem_we  <= 1'b0;
            end else if (mode_r) begin
              mem_addr <= dst_next;
            end else begin
              state    <= READ;
              mem_we   <= 1'b0;
              mem_re   <= 1'b1;
              mem_addr <= src_next;
            end
          end else if (abort) begin
            state   <= FIN;
            done    <= 1'b1;
            aborted <= 1'b1;
            busy    <= 1'b0;
            mem_we  <= 1'b0;
          end
        end

        FIN: begin
          state   <= IDLE;
          aborted <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dma.sv
// tb_ram_dma: directed bench for ram_dma with a byte RAM model and a write scoreboard.
// Honours DMA_BACKWARD_COPY_EN for the overlapping-copy expectation.
module tb_ram_dma;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        mode;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] length;
  logic [7:0]  fill_value;
  logic        abort;
  logic        busy;
  logic        done;
  logic        error;
  logic        aborted;
  logic [15:0] count_left;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  logic [7:0]  ram [0:65535];
  logic        tb_we;
  logic [15:0] tb_addr;
  logic [7:0]  tb_data;

  wr_t         sb [$];
  wr_t         mon_w;
  int          checks = 0;
  int          errors = 0;
  int          access_count = 0;
  int          access_before;
  int          done_cyc;
  int          err_cyc;
  logic        done_aborted;
  logic [15:0] done_count;
  logic [31:0] we_mask;
  logic [31:0] re_mask;
  logic [31:0] busy_mask;
  logic        unstable;
  logic [15:0] ref_addr;
  logic [7:0]  ref_wdata;

  always #5 clk = ~clk;

  ram_dma dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .fill_value (fill_value),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .aborted    (aborted),
    .count_left (count_left),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  assign mem_rdata = ram[mem_addr];

  always @(posedge clk) begin
    if (tb_we) ram[tb_addr] <= tb_data;
    else if (mem_we && mem_ready) ram[mem_addr] <= mem_wdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Every write the DUT commits must match the next entry queued by the stimulus.
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_we || mem_re) begin
        access_count++;
        checkOutput("re_we_exclusive", 32'(mem_we & mem_re), 32'd0);
      end
      if (mem_we && mem_ready) begin
        if (sb.size() == 0) begin
          checkOutput("sb_unexpected_write", {8'h00, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
        end else begin
          mon_w = sb.pop_front();
          checkOutput("sb_write_addr", 32'(mem_addr), 32'(mon_w.addr));
          checkOutput("sb_write_data", 32'(mem_wdata), 32'(mon_w.data));
        end
      end
    end
  end

  task automatic expectWrite(input logic [15:0] a, input logic [7:0] d);
    wr_t w;
    w = {a, d};
    sb.push_back(w);
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we   = 1'b1;
    tb_addr = a;
    tb_data = d;
    @(negedge clk);
    tb_we   = 1'b0;
  endtask

  task automatic applyStimulus(input logic m, input logic [15:0] s, input logic [15:0] d,
                               input logic [15:0] l, input logic [7:0] f);
    @(negedge clk);
    start      = 1'b1;
    mode       = m;
    src_addr   = s;
    dst_addr   = d;
    length     = l;
    fill_value = f;
    @(posedge clk);
    #1;
    start = 1'b0;
    access_before = access_count;
  endtask

  // Samples cycles T0+1.. until done or error, shaping mem_ready and abort per cycle.
  task automatic runCycles(input int budget, input int stall_from, input int stall_len, input int abort_at);
    done_cyc     = 0;
    err_cyc      = 0;
    done_aborted = 1'b0;
    done_count   = '0;
    we_mask      = '0;
    re_mask      = '0;
    busy_mask    = '0;
    unstable     = 1'b0;
    mem_ready    = !(stall_len > 0 && 1 >= stall_from && 1 < stall_from + stall_len);
    abort        = (abort_at == 1);
    for (int i = 1; i <= budget; i++) begin
      if (i > 1) begin
        @(posedge clk);
        #1;
        mem_ready = !(stall_len > 0 && i >= stall_from && i < stall_from + stall_len);
        abort     = (abort_at == i);
      end
      @(negedge clk);
      if (i < 32) begin
        we_mask[i]   = mem_we;
        re_mask[i]   = mem_re;
        busy_mask[i] = busy;
      end
      if (i == stall_from) begin
        ref_addr  = mem_addr;
        ref_wdata = mem_wdata;
      end
      if (stall_len > 0 && i > stall_from && i <= stall_from + stall_len &&
          (mem_addr !== ref_addr || mem_wdata !== ref_wdata))
        unstable = 1'b1;
      if (done) begin
        done_cyc     = i;
        done_aborted = aborted;
        done_count   = count_left;
        break;
      end
      if (error) begin
        err_cyc = i;
        break;
      end
    end
    mem_ready = 1'b1;
    abort     = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    mode       = 1'b0;
    src_addr   = '0;
    dst_addr   = '0;
    length     = '0;
    fill_value = '0;
    abort      = 1'b0;
    mem_ready  = 1'b1;
    tb_we      = 1'b0;
    tb_addr    = '0;
    tb_data    = '0;

    #12;
    checkOutput("reset_ctrl", 32'({busy, done, error, aborted, mem_we, mem_re}), 32'd0);
    checkOutput("reset_count_left", 32'(count_left), 32'd0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] fill 4 bytes of AA at 0x0100");
    for (int i = 0; i < 4; i++) expectWrite(16'h0100 + 16'(i), 8'hAA);
    applyStimulus(1'b1, 16'h0000, 16'h0100, 16'd4, 8'hAA);
    runCycles(20, 0, 0, 0);
    checkOutput("fill_done_cycle", 32'(done_cyc), 32'd5);
    checkOutput("fill_we_cycles", we_mask, 32'h1E);
    checkOutput("fill_re_cycles", re_mask, 32'h0);
    checkOutput("fill_busy_cycles", busy_mask, 32'h1E);
    checkOutput("fill_count_left", 32'(done_count), 32'd0);
    checkOutput("fill_aborted", 32'(done_aborted), 32'd0);
    checkOutput("fill_ram", {ram[16'h0100], ram[16'h0101], ram[16'h0102], ram[16'h0103]}, 32'hAAAA_AAAA);

    $display("[TB] copy 3 bytes 0x0200 -> 0x0300");
    poke(16'h0200, 8'h11);
    poke(16'h0201, 8'h22);
    poke(16'h0202, 8'h33);
    expectWrite(16'h0300, 8'h11);
    expectWrite(16'h0301, 8'h22);
    expectWrite(16'h0302, 8'h33);
    applyStimulus(1'b0, 16'h0200, 16'h0300, 16'd3, 8'h00);
    runCycles(20, 0, 0, 0);
    checkOutput("copy_done_cycle", 32'(done_cyc), 32'd7);
    checkOutput("copy_re_cycles", re_mask, 32'h2A);
    checkOutput("copy_we_cycles", we_mask, 32'h54);
    checkOutput("copy_count_left", 32'(done_count), 32'd0);
    checkOutput("copy_ram", {8'h00, ram[16'h0300], ram[16'h0301], ram[16'h0302]}, 32'h0011_2233);

    $display("[TB] zero-length command");
    applyStimulus(1'b1, 16'h0000, 16'h0100, 16'd0, 8'h55);
    runCycles(10, 0, 0, 0);
    checkOutput("noop_done_cycle", 32'(done_cyc), 32'd1);
    checkOutput("noop_accesses", 32'(access_count - access_before), 32'd0);
    checkOutput("noop_busy", busy_mask, 32'h0);
    checkOutput("noop_ram", 32'(ram[16'h0100]), 32'hAA);

    $display("[TB] copy source past top of memory");
    applyStimulus(1'b0, 16'hFFFE, 16'h0A00, 16'd3, 8'h00);
    runCycles(6, 0, 0, 0);
    checkOutput("src_range_error_cycle", 32'(err_cyc), 32'd1);
    checkOutput("src_range_no_done", 32'(done_cyc), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("src_range_busy", busy_mask | 32'(busy), 32'h0);
    checkOutput("src_range_accesses", 32'(access_count - access_before), 32'd0);

    $display("[TB] fill ending exactly at 0xFFFF, then one byte past it");
    for (int i = 0; i < 4; i++) expectWrite(16'hFFFC + 16'(i), 8'h77);
    applyStimulus(1'b1, 16'h0000, 16'hFFFC, 16'd4, 8'h77);
    runCycles(20, 0, 0, 0);
    checkOutput("top_fill_done_cycle", 32'(done_cyc), 32'd5);
    checkOutput("top_fill_ram", {ram[16'hFFFC], ram[16'hFFFD], ram[16'hFFFE], ram[16'hFFFF]}, 32'h7777_7777);
    applyStimulus(1'b1, 16'h0000, 16'hFFFD, 16'd4, 8'h66);
    runCycles(6, 0, 0, 0);
    checkOutput("dst_range_error_cycle", 32'(err_cyc), 32'd1);
    checkOutput("dst_range_ram", 32'(ram[16'hFFFD]), 32'h77);

    $display("[TB] 2-byte fill with a 3-cycle stall on the first write");
    expectWrite(16'h0500, 8'h5C);
    expectWrite(16'h0501, 8'h5C);
    applyStimulus(1'b1, 16'h0000, 16'h0500, 16'd2, 8'h5C);
    runCycles(20, 1, 3, 0);
    checkOutput("stall_done_cycle", 32'(done_cyc), 32'd6);
    checkOutput("stall_outputs_stable", 32'(unstable), 32'd0);
    checkOutput("stall_we_cycles", we_mask, 32'h3E);
    checkOutput("stall_ram", {16'h0000, ram[16'h0500], ram[16'h0501]}, 32'h5C5C);

    $display("[TB] abort during the second read of a 4-byte copy");
    for (int i = 0; i < 4; i++) poke(16'h0600 + 16'(i), 8'hA0 + 8'(i));
    poke(16'h0701, 8'hEE);
    expectWrite(16'h0700, 8'hA0);
    applyStimulus(1'b0, 16'h0600, 16'h0700, 16'd4, 8'h00);
    runCycles(20, 0, 0, 3);
    checkOutput("abort_done_cycle", 32'(done_cyc), 32'd4);
    checkOutput("abort_flag", 32'(done_aborted), 32'd1);
    checkOutput("abort_count_left", 32'(done_count), 32'd3);
    checkOutput("abort_re_cycles", re_mask, 32'hA);
    checkOutput("abort_we_cycles", we_mask, 32'h4);
    checkOutput("abort_ram", {16'h0000, ram[16'h0700], ram[16'h0701]}, 32'hA0EE);
    @(negedge clk);
    checkOutput("abort_flags_clear", 32'({done, aborted, busy}), 32'd0);

    $display("[TB] overlapping copy 0x0400 -> 0x0401");
    for (int i = 0; i < 4; i++) poke(16'h0400 + 16'(i), 8'h01 + 8'(i));
    poke(16'h0404, 8'h00);
`ifdef DMA_BACKWARD_COPY_EN
    for (int i = 3; i >= 0; i--) expectWrite(16'h0401 + 16'(i), 8'h01 + 8'(i));
`else
    for (int i = 0; i < 4; i++) expectWrite(16'h0401 + 16'(i), 8'h01);
`endif
    applyStimulus(1'b0, 16'h0400, 16'h0401, 16'd4, 8'h00);
    runCycles(30, 0, 0, 0);
    checkOutput("overlap_done_cycle", 32'(done_cyc), 32'd9);
`ifdef DMA_BACKWARD_COPY_EN
    checkOutput("overlap_ram", {ram[16'h0401], ram[16'h0402], ram[16'h0403], ram[16'h0404]}, 32'h0102_0304);
`else
    checkOutput("overlap_ram", {ram[16'h0401], ram[16'h0402], ram[16'h0403], ram[16'h0404]}, 32'h0101_0101);
`endif

    $display("[TB] reset asserted mid-copy, then a fresh fill");
    poke(16'h0800, 8'h99);
    expectWrite(16'h0800, 8'h11);
    applyStimulus(1'b0, 16'h0200, 16'h0800, 16'd3, 8'h00);
    runCycles(2, 0, 0, 0);
    checkOutput("midreset_pre_we", 32'(mem_we), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_ctrl", 32'({busy, done, error, aborted, mem_we, mem_re}), 32'd0);
    checkOutput("midreset_count_left", 32'(count_left), 32'd0);
    checkOutput("midreset_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("midreset_mem_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("midreset_ram_untouched", 32'(ram[16'h0800]), 32'h99);
    expectWrite(16'h0900, 8'h3C);
    expectWrite(16'h0901, 8'h3C);
    applyStimulus(1'b1, 16'h0000, 16'h0900, 16'd2, 8'h3C);
    runCycles(20, 0, 0, 0);
    checkOutput("postreset_done_cycle", 32'(done_cyc), 32'd3);
    checkOutput("postreset_ram", {16'h0000, ram[16'h0900], ram[16'h0901]}, 32'h3C3C);

    repeat (2) @(negedge clk);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
